// File: rtl/fpu_pkg.sv
// Shared floating-point constants, flag layout and the multiplier-arbiter state encoding.
package fpu_pkg;

    localparam int FLAG_W         = 5;
    localparam int FLAG_ZERO      = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_NAN       = 3;
    localparam int FLAG_TIMEOUT   = 4;

    localparam logic [FLAG_W-1:0] FLAGS_TIMEOUT = 5'b11000;

    localparam logic [63:0] NAN_VALUE_64 = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] INF_VALUE_64 = 64'h7FF0_0000_0000_0000;
    localparam logic [31:0] NAN_VALUE_32 = 32'hFFC0_0000;
    localparam logic [31:0] INF_VALUE_32 = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    function automatic int exp_width(input int float_width);
        return (float_width == 32) ? 8 : 11;
    endfunction

    function automatic int fraction_width(input int float_width);
        return (float_width == 32) ? 23 : 52;
    endfunction

    // 32-bit patterns sit in the low half; callers truncate to their width.
    function automatic logic [63:0] nan_value(input int float_width);
        return (float_width == 32) ? {32'h0, NAN_VALUE_32} : NAN_VALUE_64;
    endfunction

    function automatic logic [63:0] inf_value(input int float_width);
        return (float_width == 32) ? {32'h0, INF_VALUE_32} : INF_VALUE_64;
    endfunction

endpackage

// File: rtl/mul_float_arbiter_if.sv
// Requester and multiplier buses of the shared-multiplier arbiter.
interface mul_float_arbiter_if #(
    parameter int FLOAT_WIDTH = 64,
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2
);
    import fpu_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op1;
    logic [NUM_REQ*FLOAT_WIDTH-1:0] req_op2;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [NUM_REQ-1:0]             rsp_ready;
    logic [FLOAT_WIDTH-1:0]         rsp_data;
    logic [FLAG_W-1:0]              rsp_flags;
    logic                           mul_start;
    logic [FLOAT_WIDTH-1:0]         mul_op1;
    logic [FLOAT_WIDTH-1:0]         mul_op2;
    logic [FLOAT_WIDTH-1:0]         mul_out;
    logic                           mul_nan;
    logic                           mul_overflow;
    logic                           mul_underflow;
    logic                           mul_zero;
    logic                           mul_done;
    logic                           busy;
    logic [ID_W-1:0]                grant_id;

    modport slave (
        input  req_valid, req_op1, req_op2, rsp_ready,
               mul_out, mul_nan, mul_overflow, mul_underflow, mul_zero, mul_done,
        output req_ready, rsp_valid, rsp_data, rsp_flags,
               mul_start, mul_op1, mul_op2, busy, grant_id
    );

    modport master (
        output req_valid, req_op1, req_op2, rsp_ready,
               mul_out, mul_nan, mul_overflow, mul_underflow, mul_zero, mul_done,
        input  req_ready, rsp_valid, rsp_data, rsp_flags,
               mul_start, mul_op1, mul_op2, busy, grant_id
    );

endinterface

// File: rtl/mul_float_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or above the pointer, wrapping.
// Purely combinational; no state.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_vld
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_vld   = 1'b0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = ID_W'(w_idx);
                o_vld          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_float_arbiter.sv
// Purpose: share one mul_float between NUM_REQ requesters with round-robin grant and a watchdog.
// Latency: accept -> start 1 cycle, response the cycle after qualified done (6 cycles nominal).
// Backpressure: req_ready only in IDLE; response held until rsp_ready of the owner, one op in flight.
module mul_float_arbiter
    import fpu_pkg::*;
#(
    parameter int FLOAT_WIDTH = 64,
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    mul_float_arbiter_if.slave  ifc
);

    localparam int                     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [FLOAT_WIDTH-1:0] NAN_PAT = FLOAT_WIDTH'(nan_value(FLOAT_WIDTH));

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [ID_W-1:0]        r_ptr;
    logic [ID_W-1:0]        r_grant_id;
    logic [FLOAT_WIDTH-1:0] r_op1;
    logic [FLOAT_WIDTH-1:0] r_op2;
    logic [FLOAT_WIDTH-1:0] r_rsp_data;
    logic [FLAG_W-1:0]      r_rsp_flags;
    logic                   r_seen_low;
    logic [WD_W-1:0]        r_wdog;

    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_win_idx;
    logic                   w_win_vld;
    logic [ID_W-1:0]        w_ptr_nxt;
    logic                   w_done;
    logic                   w_timeout;
    logic [NUM_REQ-1:0]     w_req_ready;
    logic [NUM_REQ-1:0]     w_rsp_valid;
    logic                   w_start;
    logic [FLAG_W-1:0]      w_mul_flags;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req   (ifc.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx),
        .o_vld   (w_win_vld)
    );

    assign w_ptr_nxt = (w_win_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
    // mul_done stays high from the previous op for a couple of cycles; trust it only after a low.
    assign w_done    = r_seen_low & ifc.mul_done;
    assign w_timeout = (r_wdog == WD_W'(TIMEOUT - 1));

    always_comb begin
        w_mul_flags                 = '0;
        w_mul_flags[FLAG_NAN]       = ifc.mul_nan;
        w_mul_flags[FLAG_OVERFLOW]  = ifc.mul_overflow;
        w_mul_flags[FLAG_UNDERFLOW] = ifc.mul_underflow;
        w_mul_flags[FLAG_ZERO]      = ifc.mul_zero;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_rsp_valid = '0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = w_grant;
                if (w_win_vld) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                w_start     = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_done || w_timeout) w_state_nxt = RESP;
            end
            RESP: begin
                w_rsp_valid[r_grant_id] = 1'b1;
                if (ifc.rsp_ready[r_grant_id]) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_seen_low  <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_win_vld) begin
                        r_op1      <= ifc.req_op1[int'(w_win_idx)*FLOAT_WIDTH +: FLOAT_WIDTH];
                        r_op2      <= ifc.req_op2[int'(w_win_idx)*FLOAT_WIDTH +: FLOAT_WIDTH];
                        r_grant_id <= w_win_idx;
                        r_ptr      <= w_ptr_nxt;
                    end
                end
                ISSUE: begin
                    r_seen_low <= 1'b0;
                    r_wdog     <= '0;
                end
                WAIT: begin
                    if (!ifc.mul_done) r_seen_low <= 1'b1;
                    if (w_done) begin
                        r_rsp_data  <= ifc.mul_out;
                        r_rsp_flags <= w_mul_flags;
                    end else if (w_timeout) begin
                        r_rsp_data  <= NAN_PAT;
                        r_rsp_flags <= FLAGS_TIMEOUT;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ifc.req_ready = w_req_ready;
    assign ifc.rsp_valid = w_rsp_valid;
    assign ifc.rsp_data  = r_rsp_data;
    assign ifc.rsp_flags = r_rsp_flags;
    assign ifc.mul_start = w_start;
    assign ifc.mul_op1   = r_op1;
    assign ifc.mul_op2   = r_op2;
    assign ifc.busy      = (r_state != IDLE);
    assign ifc.grant_id  = r_grant_id;

endmodule

// File: tb/tb_mul_float_arbiter.sv
// Bench for mul_float_arbiter: behavioural multiplier with stale done, scoreboard of expected responses.
module tb_mul_float_arbiter;

    localparam int FW      = 64;
    localparam int NR      = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 15;

    typedef struct {
        int          id;
        logic [63:0] data;
        logic [4:0]  flags;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_float_arbiter_if #(.FLOAT_WIDTH(FW), .NUM_REQ(NR), .ID_W(IDW)) bus();

    mul_float_arbiter #(
        .FLOAT_WIDTH (FW),
        .NUM_REQ     (NR),
        .ID_W        (IDW),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    // Result + {nan, overflow, underflow, zero}; zero*inf and NaN inputs give canonical NaN.
    function automatic logic [67:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic        a_inf, b_inf, a_nan, b_nan, a_zero, b_zero, ovf;
        logic [63:0] r;
        a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'h0);
        b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'h0);
        a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'h0);
        b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'h0);
        a_zero = (a[62:0] == 63'h0);
        b_zero = (b[62:0] == 63'h0);
        if (a_nan || b_nan || (a_zero && b_inf) || (b_zero && a_inf))
            return {4'b1000, 64'h7FF8_0000_0000_0000};
        r   = $realtobits($bitstoreal(a) * $bitstoreal(b));
        ovf = (r[62:52] == 11'h7FF) && !a_inf && !b_inf;
        return {1'b0, ovf, 1'b0, (r[62:0] == 63'h0), r};
    endfunction

    int          mcnt  = 0;
    bit          stuck = 1'b0;
    logic [67:0] mres;

    always @(posedge clk) begin
        if (bus.mul_start) mcnt <= 1;
        else if (mcnt != 0 && mcnt < 4) mcnt <= mcnt + 1;
    end
    always_comb mres = ref_mul(bus.mul_op1, bus.mul_op2);
    assign bus.mul_out = mres[63:0];
    assign {bus.mul_nan, bus.mul_overflow, bus.mul_underflow, bus.mul_zero} = mres[67:64];
    assign bus.mul_done = stuck ? 1'b0 : !(mcnt == 2 || mcnt == 3);

    task automatic wait_rsp(input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < limit && !ok) begin
            @(negedge clk);
            cycles++;
            if (bus.rsp_valid != '0) ok = 1'b1;
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok     = (sb.size() > 0);
        e.id   = -1;
        e.data = '0;
        e.flags = '0;
        if (ok) e = sb.pop_front();
    endtask

    task automatic handshake(input int id);
        bus.rsp_ready[id] = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = '0;
    endtask

    task automatic drive_req(input int id, input logic [63:0] a, input logic [63:0] b);
        bus.req_op1[id*FW +: FW] = a;
        bus.req_op2[id*FW +: FW] = b;
        bus.req_valid[id]        = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp += 8;
        if (bus.req_ready !== 4'h0) begin n_bad++; $display("FAIL rst_req_ready got %h want 0", bus.req_ready); end
        if (bus.rsp_valid !== 4'h0) begin n_bad++; $display("FAIL rst_rsp_valid got %h want 0", bus.rsp_valid); end
        if (bus.rsp_data !== 64'h0) begin n_bad++; $display("FAIL rst_rsp_data got %h want 0", bus.rsp_data); end
        if (bus.rsp_flags !== 5'h0) begin n_bad++; $display("FAIL rst_rsp_flags got %b want 0", bus.rsp_flags); end
        if (bus.mul_start !== 1'b0) begin n_bad++; $display("FAIL rst_mul_start got %b want 0", bus.mul_start); end
        if (bus.mul_op1 !== 64'h0 || bus.mul_op2 !== 64'h0) begin n_bad++; $display("FAIL rst_mul_ops got %h/%h want 0", bus.mul_op1, bus.mul_op2); end
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        if (bus.grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_grant_id got %0d want 0", bus.grant_id); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fairness;
        int   cyc;
        bit   ok, got;
        exp_t e;
        logic [67:0] m;
        for (int i = 0; i < NR; i++) drive_req(i, $realtobits(1.5), $realtobits(real'(i + 2)));
        for (int k = 0; k < 5; k++) begin
            m = ref_mul($realtobits(1.5), $realtobits(real'((k % NR) + 2)));
            sb.push_back('{k % NR, m[63:0], {1'b0, m[67:64]}});
        end
        for (int k = 0; k < 5; k++) begin
            wait_rsp(40, cyc, ok);
            pop_exp(e, got);
            n_cmp++;
            if (!ok || !got) begin n_bad++; $display("FAIL rr_wait[%0d] rsp_valid never seen (queue=%0b)", k, got); continue; end
            n_cmp += 4;
            if (bus.rsp_valid !== 4'(1 << e.id)) begin n_bad++; $display("FAIL rr_order[%0d] rsp_valid %b want %b", k, bus.rsp_valid, 4'(1 << e.id)); end
            if (bus.grant_id !== IDW'(e.id)) begin n_bad++; $display("FAIL rr_grant_id[%0d] got %0d want %0d", k, bus.grant_id, e.id); end
            if (bus.rsp_data !== e.data) begin n_bad++; $display("FAIL rr_data[%0d] got %h want %h", k, bus.rsp_data, e.data); end
            if (bus.req_ready !== 4'h0) begin n_bad++; $display("FAIL rr_req_ready[%0d] got %b want 0", k, bus.req_ready); end
            handshake(e.id);
            if (k == 4) bus.req_valid = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_single;
        int   cyc;
        bit   ok, got;
        exp_t e;
        drive_req(2, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000);
        sb.push_back('{2, 64'h4018_0000_0000_0000, 5'b00000});
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_req_ready got %b want 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        n_cmp++;
        if (bus.mul_start !== 1'b1) begin n_bad++; $display("FAIL single_start got %b want 1", bus.mul_start); end
        wait_rsp(40, cyc, ok);
        pop_exp(e, got);
        n_cmp += 6;
        if (!ok || (cyc + 1) != 6) begin n_bad++; $display("FAIL single_latency got %0d want 6", cyc + 1); end
        if (bus.rsp_valid !== 4'(1 << e.id)) begin n_bad++; $display("FAIL single_rsp_valid got %b want %b", bus.rsp_valid, 4'(1 << e.id)); end
        if (bus.rsp_data !== e.data) begin n_bad++; $display("FAIL single_data got %h want %h", bus.rsp_data, e.data); end
        if (bus.rsp_flags !== e.flags) begin n_bad++; $display("FAIL single_flags got %b want %b", bus.rsp_flags, e.flags); end
        if (bus.mul_op1 !== 64'h4000_0000_0000_0000 || bus.mul_op2 !== 64'h4008_0000_0000_0000) begin
            n_bad++; $display("FAIL single_ops_held got %h/%h", bus.mul_op1, bus.mul_op2);
        end
        if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", bus.busy); end
        handshake(2);
        @(negedge clk);
        n_cmp += 2;
        if (bus.rsp_valid !== 4'h0) begin n_bad++; $display("FAIL single_rsp_drop got %b want 0", bus.rsp_valid); end
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_zero_inf;
        int   cyc;
        bit   ok, got;
        exp_t e;
        drive_req(3, 64'h0, 64'h7FF0_0000_0000_0000);
        sb.push_back('{3, 64'h7FF8_0000_0000_0000, 5'b01000});
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(40, cyc, ok);
        pop_exp(e, got);
        n_cmp += 3;
        if (!ok || bus.rsp_valid !== 4'(1 << e.id)) begin n_bad++; $display("FAIL zinf_rsp_valid got %b want %b", bus.rsp_valid, 4'(1 << e.id)); end
        if (bus.rsp_data !== e.data) begin n_bad++; $display("FAIL zinf_data got %h want %h", bus.rsp_data, e.data); end
        if (bus.rsp_flags !== e.flags) begin n_bad++; $display("FAIL zinf_flags got %b want %b", bus.rsp_flags, e.flags); end
        handshake(3);
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int   cyc;
        bit   ok, got;
        int   bad_hold;
        exp_t e;
        drive_req(1, $realtobits(1.5), $realtobits(2.0));
        sb.push_back('{1, 64'h4008_0000_0000_0000, 5'b00000});
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(40, cyc, ok);
        pop_exp(e, got);
        n_cmp++;
        if (!ok || !got) begin n_bad++; $display("FAIL bp_wait rsp_valid never seen"); end
        drive_req(0, $realtobits(2.5), $realtobits(4.0));
        sb.push_back('{0, 64'h4024_0000_0000_0000, 5'b00000});
        bus.rsp_ready[0] = 1'b1;
        bad_hold = 0;
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== e.data || bus.req_ready !== 4'h0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] rsp_valid %b data %h req_ready %b want 0010 %h 0000", c, bus.rsp_valid, bus.rsp_data, bus.req_ready, e.data);
            end
            @(negedge clk);
        end
        handshake(1);
        @(negedge clk);
        n_cmp += 2;
        if (bus.rsp_valid !== 4'h0) begin n_bad++; $display("FAIL bp_rsp_drop got %b want 0", bus.rsp_valid); end
        if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_next_grant got %b want 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(40, cyc, ok);
        pop_exp(e, got);
        n_cmp += 2;
        if (!ok || bus.rsp_valid !== 4'(1 << e.id)) begin n_bad++; $display("FAIL bp_second_valid got %b want %b", bus.rsp_valid, 4'(1 << e.id)); end
        if (bus.rsp_data !== e.data) begin n_bad++; $display("FAIL bp_second_data got %h want %h", bus.rsp_data, e.data); end
        handshake(0);
        @(negedge clk);
    endtask

    task automatic test_watchdog;
        int   cyc;
        bit   ok, got;
        exp_t e;
        stuck = 1'b1;
        drive_req(2, $realtobits(3.0), $realtobits(3.0));
        sb.push_back('{2, 64'h7FF8_0000_0000_0000, 5'b11000});
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(60, cyc, ok);
        pop_exp(e, got);
        n_cmp += 4;
        if (!ok || (cyc + 1) != TIMEOUT + 2) begin n_bad++; $display("FAIL wd_latency got %0d want %0d", cyc + 1, TIMEOUT + 2); end
        if (bus.rsp_valid !== 4'(1 << e.id)) begin n_bad++; $display("FAIL wd_rsp_valid got %b want %b", bus.rsp_valid, 4'(1 << e.id)); end
        if (bus.rsp_data !== e.data) begin n_bad++; $display("FAIL wd_data got %h want %h", bus.rsp_data, e.data); end
        if (bus.rsp_flags !== e.flags) begin n_bad++; $display("FAIL wd_flags got %b want %b", bus.rsp_flags, e.flags); end
        handshake(2);
        stuck = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int   cyc;
        bit   ok, got;
        exp_t e;
        drive_req(1, $realtobits(2.0), $realtobits(2.0));
        sb.push_back('{1, 64'h4010_0000_0000_0000, 5'b00000});
        repeat (3) @(negedge clk);
        #2;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        sb.delete();
        #1;
        n_cmp += 5;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
        if (bus.rsp_valid !== 4'h0 || bus.req_ready !== 4'h0) begin n_bad++; $display("FAIL rmid_valids rsp %b req %b want 0", bus.rsp_valid, bus.req_ready); end
        if (bus.mul_op1 !== 64'h0 || bus.mul_op2 !== 64'h0) begin n_bad++; $display("FAIL rmid_ops got %h/%h want 0", bus.mul_op1, bus.mul_op2); end
        if (bus.grant_id !== 2'd0) begin n_bad++; $display("FAIL rmid_grant_id got %0d want 0", bus.grant_id); end
        if (bus.mul_start !== 1'b0 || bus.rsp_flags !== 5'h0) begin n_bad++; $display("FAIL rmid_start_flags got %b/%b want 0", bus.mul_start, bus.rsp_flags); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_req(3, $realtobits(5.0), $realtobits(2.0));
        drive_req(0, $realtobits(0.5), $realtobits(3.0));
        sb.push_back('{0, 64'h3FF8_0000_0000_0000, 5'b00000});
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL rmid_first_grant got %b want 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        wait_rsp(40, cyc, ok);
        pop_exp(e, got);
        n_cmp += 2;
        if (!ok || bus.rsp_valid !== 4'(1 << e.id)) begin n_bad++; $display("FAIL rmid_rsp_valid got %b want %b", bus.rsp_valid, 4'(1 << e.id)); end
        if (bus.rsp_data !== e.data) begin n_bad++; $display("FAIL rmid_data got %h want %h", bus.rsp_data, e.data); end
        handshake(0);
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.rsp_ready = '0;
        test_reset();
        test_fairness();
        test_single();
        test_zero_inf();
        test_backpressure();
        test_watchdog();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish by 100000");
        $fatal(1);
    end

endmodule
